// File: rtl/mips_cpu_bus.sv
// ============================================================================
//  Module   : mips_cpu_bus
//  Purpose  : Multicycle MIPS32 subset CPU with one shared Avalon-MM style
//             memory port used for both instruction fetch and data access.
//             Boots at RESET_VECTOR, halts when it would fetch address 0.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_cpu_bus #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    // Primary opcodes
    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_J       = 6'h02;
    localparam logic [5:0] c_OP_JAL     = 6'h03;
    localparam logic [5:0] c_OP_BEQ     = 6'h04;
    localparam logic [5:0] c_OP_BNE     = 6'h05;
    localparam logic [5:0] c_OP_ADDIU   = 6'h09;
    localparam logic [5:0] c_OP_SLTI    = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU   = 6'h0B;
    localparam logic [5:0] c_OP_ANDI    = 6'h0C;
    localparam logic [5:0] c_OP_ORI     = 6'h0D;
    localparam logic [5:0] c_OP_XORI    = 6'h0E;
    localparam logic [5:0] c_OP_LUI     = 6'h0F;
    localparam logic [5:0] c_OP_LW      = 6'h23;
    localparam logic [5:0] c_OP_SW      = 6'h2B;

    // SPECIAL function codes
    localparam logic [5:0] c_FN_SLL  = 6'h00;
    localparam logic [5:0] c_FN_SRL  = 6'h02;
    localparam logic [5:0] c_FN_SRA  = 6'h03;
    localparam logic [5:0] c_FN_JR   = 6'h08;
    localparam logic [5:0] c_FN_JALR = 6'h09;
    localparam logic [5:0] c_FN_ADDU = 6'h21;
    localparam logic [5:0] c_FN_SUBU = 6'h23;
    localparam logic [5:0] c_FN_AND  = 6'h24;
    localparam logic [5:0] c_FN_OR   = 6'h25;
    localparam logic [5:0] c_FN_XOR  = 6'h26;
    localparam logic [5:0] c_FN_SLT  = 6'h2A;
    localparam logic [5:0] c_FN_SLTU = 6'h2B;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_active;

    logic [31:0] r_pc;          // address of the instruction being executed
    logic        r_br_pending;  // a branch/jump resolved, slot still to run
    logic [31:0] r_br_target;
    logic [31:0] r_gpr [0:31];

    logic [31:0] r_mem_addr;
    logic [31:0] r_wdata;
    logic        r_is_store;
    logic [4:0]  r_load_rt;

    // Instruction fields: the fetched word is only valid during EXEC
    logic [31:0] w_ir;
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [31:0] w_simm;
    logic [31:0] w_zimm;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_pc4;
    logic [31:0] w_pc8;
    logic [31:0] w_next_pc;
    logic [31:0] w_mem_addr;

    logic        w_wr_en;
    logic [4:0]  w_wr_idx;
    logic [31:0] w_wr_data;
    logic        w_jump;
    logic [31:0] w_jump_target;
    logic        w_is_load;
    logic        w_is_store;

    assign w_ir       = readdata;
    assign w_op       = w_ir[31:26];
    assign w_rs       = w_ir[25:21];
    assign w_rt       = w_ir[20:16];
    assign w_rd       = w_ir[15:11];
    assign w_shamt    = w_ir[10:6];
    assign w_funct    = w_ir[5:0];
    assign w_simm     = {{16{w_ir[15]}}, w_ir[15:0]};
    assign w_zimm     = {16'h0000, w_ir[15:0]};
    assign w_rs_val   = (w_rs == 5'd0) ? 32'h0 : r_gpr[w_rs];
    assign w_rt_val   = (w_rt == 5'd0) ? 32'h0 : r_gpr[w_rt];
    assign w_pc4      = r_pc + 32'd4;
    assign w_pc8      = r_pc + 32'd8;
    // The delay slot runs first; a resolved target takes effect after it
    assign w_next_pc  = r_br_pending ? r_br_target : w_pc4;
    assign w_mem_addr = (w_rs_val + w_simm) & 32'hFFFF_FFFC;

    assign active      = r_active;
    assign register_v0 = r_gpr[2];

    // Decode and ALU: result, destination and control flow of the current IR
    always_comb begin
        w_wr_en       = 1'b0;
        w_wr_idx      = w_rd;
        w_wr_data     = 32'h0;
        w_jump        = 1'b0;
        w_jump_target = 32'h0;
        w_is_load     = 1'b0;
        w_is_store    = 1'b0;
        case (w_op)
            c_OP_SPECIAL: begin
                w_wr_en = 1'b1;
                case (w_funct)
                    c_FN_ADDU: w_wr_data = w_rs_val + w_rt_val;
                    c_FN_SUBU: w_wr_data = w_rs_val - w_rt_val;
                    c_FN_AND:  w_wr_data = w_rs_val & w_rt_val;
                    c_FN_OR:   w_wr_data = w_rs_val | w_rt_val;
                    c_FN_XOR:  w_wr_data = w_rs_val ^ w_rt_val;
                    c_FN_SLT:  w_wr_data = ($signed(w_rs_val) < $signed(w_rt_val)) ? 32'd1 : 32'd0;
                    c_FN_SLTU: w_wr_data = (w_rs_val < w_rt_val) ? 32'd1 : 32'd0;
                    c_FN_SLL:  w_wr_data = w_rt_val << w_shamt;
                    c_FN_SRL:  w_wr_data = w_rt_val >> w_shamt;
                    c_FN_SRA:  w_wr_data = $unsigned($signed(w_rt_val) >>> w_shamt);
                    c_FN_JR: begin
                        w_wr_en       = 1'b0;
                        w_jump        = 1'b1;
                        w_jump_target = w_rs_val;
                    end
                    c_FN_JALR: begin
                        w_wr_data     = w_pc8;
                        w_jump        = 1'b1;
                        w_jump_target = w_rs_val;
                    end
                    default:   w_wr_en = 1'b0;
                endcase
            end
            c_OP_J: begin
                w_jump        = 1'b1;
                w_jump_target = {w_pc4[31:28], w_ir[25:0], 2'b00};
            end
            c_OP_JAL: begin
                w_jump        = 1'b1;
                w_jump_target = {w_pc4[31:28], w_ir[25:0], 2'b00};
                w_wr_en       = 1'b1;
                w_wr_idx      = 5'd31;
                w_wr_data     = w_pc8;
            end
            c_OP_BEQ: begin
                w_jump        = (w_rs_val == w_rt_val);
                w_jump_target = w_pc4 + (w_simm << 2);
            end
            c_OP_BNE: begin
                w_jump        = (w_rs_val != w_rt_val);
                w_jump_target = w_pc4 + (w_simm << 2);
            end
            c_OP_ADDIU: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = w_rt;
                w_wr_data = w_rs_val + w_simm;
            end
            c_OP_SLTI: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = w_rt;
                w_wr_data = ($signed(w_rs_val) < $signed(w_simm)) ? 32'd1 : 32'd0;
            end
            c_OP_SLTIU: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = w_rt;
                w_wr_data = (w_rs_val < w_simm) ? 32'd1 : 32'd0;
            end
            c_OP_ANDI: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = w_rt;
                w_wr_data = w_rs_val & w_zimm;
            end
            c_OP_ORI: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = w_rt;
                w_wr_data = w_rs_val | w_zimm;
            end
            c_OP_XORI: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = w_rt;
                w_wr_data = w_rs_val ^ w_zimm;
            end
            c_OP_LUI: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = w_rt;
                w_wr_data = {w_ir[15:0], 16'h0000};
            end
            c_OP_LW:  w_is_load  = 1'b1;
            c_OP_SW:  w_is_store = 1'b1;
            default:  w_wr_en    = 1'b0;
        endcase
    end

    // Next state and bus outputs; bus outputs depend only on registered state
    always_comb begin
        w_state_nxt = r_state;
        address     = r_pc;
        read        = 1'b0;
        write       = 1'b0;
        byteenable  = 4'b1111;
        writedata   = r_wdata;
        case (r_state)
            S_FETCH: begin
                read = r_active;
                if (r_active && !waitrequest) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_is_load || w_is_store) begin
                    w_state_nxt = S_MEM;
                end else if (w_next_pc == 32'h0) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_MEM: begin
                address = r_mem_addr;
                read    = !r_is_store;
                write   = r_is_store;
                if (!waitrequest) begin
                    if (!r_is_store) begin
                        w_state_nxt = S_WB;
                    end else if (r_pc == 32'h0) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_WB: begin
                w_state_nxt = (r_pc == 32'h0) ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_HALT;
            end
        endcase
    end

    // State register; active rises on the first edge out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= (w_state_nxt != S_HALT);
        end
    end

    // PC and pending branch target advance once per instruction, in EXEC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_VECTOR;
            r_br_pending <= 1'b0;
            r_br_target  <= 32'h0;
        end else if (r_state == S_EXEC) begin
            r_pc         <= w_next_pc;
            r_br_pending <= w_jump;
            r_br_target  <= w_jump_target;
        end
    end

    // Latch load/store address, store data and load destination for MEM/WB
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_addr <= 32'h0;
            r_wdata    <= 32'h0;
            r_is_store <= 1'b0;
            r_load_rt  <= 5'd0;
        end else if ((r_state == S_EXEC) && (w_is_load || w_is_store)) begin
            r_mem_addr <= w_mem_addr;
            r_wdata    <= w_rt_val;
            r_is_store <= w_is_store;
            r_load_rt  <= w_rt;
        end
    end

    // Register file write-back; $0 is never written
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_gpr[i] <= 32'h0;
            end
        end else if ((r_state == S_EXEC) && w_wr_en && (w_wr_idx != 5'd0)) begin
            r_gpr[w_wr_idx] <= w_wr_data;
        end else if ((r_state == S_WB) && (r_load_rt != 5'd0)) begin
            r_gpr[r_load_rt] <= readdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_bus.sv
// ============================================================================
//  Module   : tb_mips_cpu_bus
//  Purpose  : Self-checking bench for mips_cpu_bus with a RAM model that can
//             insert wait states on every access.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_cpu_bus;

    localparam logic [31:0] c_BASE = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];
    int          waits = 0;
    int          wcnt  = 0;
    logic [31:0] r_rdata = 32'h0;

    // Scoreboard queues
    logic [31:0] exp_v0 [$];
    logic [67:0] exp_wr [$];
    logic [67:0] obs_wr [$];

    // Bus monitor counters
    int          both_cnt   = 0;
    int          zero_cnt   = 0;
    int          stall_bad  = 0;
    int          stall_seen = 0;
    bit          stall_pend = 0;
    logic [31:0] st_addr;
    logic        st_rd;
    logic        st_wr;

    always #5 clk = ~clk;

    mips_cpu_bus #(.RESET_VECTOR(32'hBFC00000)) dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    assign waitrequest = (read || write) && (wcnt < waits);
    assign readdata    = r_rdata;

    function automatic bit in_ram(input logic [31:0] a);
        return (a & 32'hFFFF_FC00) == c_BASE;
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - c_BASE;
        return int'(off >> 2);
    endfunction

    // RAM model: each access is stalled for `waits` cycles, then accepted
    always @(posedge clk) begin
        if (!reset) begin
            wcnt <= 0;
        end else if (read || write) begin
            if (wcnt < waits) begin
                wcnt <= wcnt + 1;
            end else begin
                wcnt <= 0;
                if (read) r_rdata <= in_ram(address) ? mem[widx(address)] : 32'h0;
                if (write && in_ram(address)) mem[widx(address)] = writedata;
            end
        end
    end

    // Bus monitor: records writes, illegal strobes and stall stability
    always @(posedge clk) begin
        if (!reset) begin
            stall_pend = 0;
        end else begin
            if (read && write) both_cnt++;
            if ((read || write) && address == 32'h0) zero_cnt++;
            if (write && !waitrequest) obs_wr.push_back({address, writedata, byteenable});
            if (stall_pend && (address != st_addr || read != st_rd || write != st_wr)) stall_bad++;
            if ((read || write) && waitrequest) begin
                stall_pend = 1;
                st_addr    = address;
                st_rd      = read;
                st_wr      = write;
                stall_seen++;
            end else begin
                stall_pend = 0;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        both_cnt   = 0;
        zero_cnt   = 0;
        stall_bad  = 0;
        stall_seen = 0;
        obs_wr.delete();
        reset = 1'b1;
    endtask

    task automatic run_to_halt(input int budget, output bit ok);
        bit seen;
        seen = 0;
        ok   = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (active) seen = 1;
            else if (seen) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL rst_active got=%b exp=0", active); end
        n_vec++; if (address !== 32'hBFC00000) begin n_err++; $display("FAIL rst_address got=%h exp=bfc00000", address); end
        n_vec++; if (read !== 1'b0) begin n_err++; $display("FAIL rst_read got=%b exp=0", read); end
        n_vec++; if (write !== 1'b0) begin n_err++; $display("FAIL rst_write got=%b exp=0", write); end
        n_vec++; if (byteenable !== 4'b1111) begin n_err++; $display("FAIL rst_byteenable got=%b exp=1111", byteenable); end
        n_vec++; if (register_v0 !== 32'h0) begin n_err++; $display("FAIL rst_v0 got=%h exp=0", register_v0); end
    endtask

    task automatic test_jal();
        bit ok;
        clear_mem();
        mem[0]  = 32'h0FF00010;   // jal 0xBFC00040
        mem[1]  = 32'h00000000;   // nop (slot)
        mem[16] = 32'h03E01021;   // addu $2,$31,$0
        mem[17] = 32'h00000008;   // jr $0
        mem[18] = 32'h00000000;   // nop
        exp_v0.push_back(32'hBFC00008);
        apply_reset();
        run_to_halt(500, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL jal_halt got=timeout exp=halt"); end
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL jal_active got=%b exp=0", active); end
        begin
            logic [31:0] e;
            e = exp_v0.pop_front();
            n_vec++; if (register_v0 !== e) begin n_err++; $display("FAIL jal_v0 got=%h exp=%h", register_v0, e); end
        end
        n_vec++; if (zero_cnt != 0) begin n_err++; $display("FAIL jal_addr0_access got=%0d exp=0", zero_cnt); end
    endtask

    task automatic load_arith();
        clear_mem();
        mem[0] = 32'h3C021234;    // lui $2,0x1234
        mem[1] = 32'h34425678;    // ori $2,$2,0x5678
        mem[2] = 32'h2442FFFF;    // addiu $2,$2,-1
        mem[3] = 32'h00000008;    // jr $0
        mem[4] = 32'h00000000;    // nop
        exp_v0.push_back(32'h12345677);
    endtask

    task automatic test_arith();
        bit ok;
        load_arith();
        apply_reset();
        run_to_halt(500, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL arith_halt got=timeout exp=halt"); end
        begin
            logic [31:0] e;
            e = exp_v0.pop_front();
            n_vec++; if (register_v0 !== e) begin n_err++; $display("FAIL arith_v0 got=%h exp=%h", register_v0, e); end
        end
    endtask

    task automatic test_alu_mix();
        bit ok;
        clear_mem();
        mem[0] = 32'h2405FFF8;    // addiu $5,$0,-8
        mem[1] = 32'h00053043;    // sra   $6,$5,1     -> -4
        mem[2] = 32'h0005382B;    // sltu  $7,$0,$5    -> 1
        mem[3] = 32'h00A0402A;    // slt   $8,$5,$0    -> 1
        mem[4] = 32'h00C71023;    // subu  $2,$6,$7    -> -5
        mem[5] = 32'h00481021;    // addu  $2,$2,$8    -> -4
        mem[6] = 32'h00000008;    // jr $0
        mem[7] = 32'h00000000;    // nop
        exp_v0.push_back(32'hFFFFFFFC);
        apply_reset();
        run_to_halt(500, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL alu_halt got=timeout exp=halt"); end
        begin
            logic [31:0] e;
            e = exp_v0.pop_front();
            n_vec++; if (register_v0 !== e) begin n_err++; $display("FAIL alu_v0 got=%h exp=%h", register_v0, e); end
        end
    endtask

    task automatic test_memory();
        bit ok;
        clear_mem();
        mem[0] = 32'h3C03DEAD;    // lui $3,0xDEAD
        mem[1] = 32'h3463BEEF;    // ori $3,$3,0xBEEF
        mem[2] = 32'h3C04BFC0;    // lui $4,0xBFC0
        mem[3] = 32'hAC830100;    // sw $3,0x100($4)
        mem[4] = 32'h8C820100;    // lw $2,0x100($4)
        mem[5] = 32'h00000008;    // jr $0
        mem[6] = 32'h00000000;    // nop
        exp_v0.push_back(32'hDEADBEEF);
        exp_wr.push_back({32'hBFC00100, 32'hDEADBEEF, 4'b1111});
        apply_reset();
        run_to_halt(500, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL mem_halt got=timeout exp=halt"); end
        begin
            logic [31:0] e;
            e = exp_v0.pop_front();
            n_vec++; if (register_v0 !== e) begin n_err++; $display("FAIL mem_v0 got=%h exp=%h", register_v0, e); end
        end
        n_vec++; if (obs_wr.size() != exp_wr.size()) begin n_err++; $display("FAIL mem_write_count got=%0d exp=%0d", obs_wr.size(), exp_wr.size()); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            logic [67:0] e;
            logic [67:0] o;
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            n_vec++; if (o !== e) begin n_err++; $display("FAIL mem_write addr/data/be got=%h exp=%h", o, e); end
        end
        exp_wr.delete();
        n_vec++; if (both_cnt != 0) begin n_err++; $display("FAIL mem_rd_wr_both got=%0d exp=0", both_cnt); end
    endtask

    task automatic test_branch();
        bit ok;
        clear_mem();
        mem[0] = 32'h10000002;    // beq $0,$0,+2
        mem[1] = 32'h24020005;    // addiu $2,$0,5  (slot)
        mem[2] = 32'h24020009;    // addiu $2,$0,9  (skipped)
        mem[3] = 32'h00000008;    // jr $0
        mem[4] = 32'h00000000;    // nop
        exp_v0.push_back(32'd5);
        apply_reset();
        run_to_halt(500, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL branch_halt got=timeout exp=halt"); end
        begin
            logic [31:0] e;
            e = exp_v0.pop_front();
            n_vec++; if (register_v0 !== e) begin n_err++; $display("FAIL branch_v0 got=%h exp=%h", register_v0, e); end
        end
    endtask

    task automatic test_wait_states();
        bit ok;
        waits = 3;
        load_arith();
        apply_reset();
        run_to_halt(1000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL wait_halt got=timeout exp=halt"); end
        begin
            logic [31:0] e;
            e = exp_v0.pop_front();
            n_vec++; if (register_v0 !== e) begin n_err++; $display("FAIL wait_v0 got=%h exp=%h", register_v0, e); end
        end
        n_vec++; if (stall_bad != 0) begin n_err++; $display("FAIL wait_stable got=%0d changes exp=0", stall_bad); end
        n_vec++; if (stall_seen != 15) begin n_err++; $display("FAIL wait_stall_cycles got=%0d exp=15", stall_seen); end
        waits = 0;
    endtask

    task automatic test_reset_mid();
        clear_mem();
        mem[0] = 32'h24020007;    // addiu $2,$0,7
        mem[1] = 32'h1000FFFF;    // beq $0,$0,-1 (spin)
        mem[2] = 32'h00000000;    // nop (slot)
        apply_reset();
        repeat (40) @(negedge clk);
        n_vec++; if (register_v0 !== 32'd7) begin n_err++; $display("FAIL rmid_pre_v0 got=%h exp=7", register_v0); end
        n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL rmid_pre_active got=%b exp=1", active); end
        reset = 1'b0;
        #1;
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL rmid_active got=%b exp=0", active); end
        n_vec++; if (address !== 32'hBFC00000) begin n_err++; $display("FAIL rmid_address got=%h exp=bfc00000", address); end
        n_vec++; if (read !== 1'b0) begin n_err++; $display("FAIL rmid_read got=%b exp=0", read); end
        n_vec++; if (register_v0 !== 32'h0) begin n_err++; $display("FAIL rmid_v0 got=%h exp=0", register_v0); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL rmid_restart_active got=%b exp=1", active); end
        n_vec++; if (address !== 32'hBFC00000 || read !== 1'b1) begin n_err++; $display("FAIL rmid_restart_fetch got=%h/%b exp=bfc00000/1", address, read); end
        n_vec++; if (register_v0 !== 32'h0) begin n_err++; $display("FAIL rmid_restart_v0 got=%h exp=0", register_v0); end
        repeat (40) @(negedge clk);
        n_vec++; if (register_v0 !== 32'd7) begin n_err++; $display("FAIL rmid_rerun_v0 got=%h exp=7", register_v0); end
    endtask

    initial begin
        reset = 1'b0;
        clear_mem();
        test_reset();
        test_jal();
        test_arith();
        test_alu_mix();
        test_memory();
        test_branch();
        test_wait_states();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
